// File: rtl/controlador_divisor.sv
// controlador_divisor: run-time controller for a programmable divided clock.
// Starts and stops clk_out/tick cleanly and swaps divide ratios only at
// full-period (falling) boundaries so clk_out never glitches.
// Optional build macro: CTRL_DIV_STATUS_EN adds the 16-bit 'periods' counter.
module controlador_divisor #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEFAULT_DIV = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             tick,
`ifdef CTRL_DIV_STATUS_EN
  output logic [15:0]      periods,
`endif
  output logic             busy
);

  typedef enum logic [1:0] {StIdle, StRun, StPend} state_e;

  localparam logic [WIDTH-1:0] One    = WIDTH'(1);
  localparam logic [WIDTH-1:0] DivRst = WIDTH'(DEFAULT_DIV);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             err_q, err_d;

  logic             xfer, xfer_ok;
  logic             terminal, fall;
  logic             div_load;
  logic [WIDTH-1:0] div_src;

  assign cfg_ready = (state_q != StPend);
  assign busy      = (state_q != StIdle);
  assign clk_out   = clk_out_q;
  assign tick      = tick_q;
  assign cfg_err   = err_q;

  assign xfer     = cfg_valid && cfg_ready;
  assign xfer_ok  = xfer && (cfg_div != '0);
  // >= rather than == so a count left larger than a newly shortened ratio still wraps
  assign terminal = (count_q >= (div_q - One));
  assign fall     = terminal && clk_out_q;

  // Next-state, counter, toggle and ratio-load decisions
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    pend_d    = pend_q;
    clk_out_d = clk_out_q;
    tick_d    = 1'b0;
    err_d     = xfer && (cfg_div == '0);
    div_load  = 1'b0;
    div_src   = cfg_div;

    unique case (state_q)
      StIdle: begin
        count_d   = '0;
        clk_out_d = 1'b0;
        if (xfer_ok) begin
          div_load = 1'b1;
          div_src  = cfg_div;
        end
        if (enable) state_d = StRun;
      end
      StRun, StPend: begin
        if (terminal) begin
          count_d   = '0;
          clk_out_d = ~clk_out_q;
          tick_d    = 1'b1;
        end else begin
          count_d = count_q + One;
        end

        // A transfer in RUN always parks in pending, even on a terminal edge
        if (state_q == StRun && xfer_ok) begin
          pend_d  = cfg_div;
          state_d = StPend;
        end

        if (fall) begin
          if (state_q == StPend) begin
            div_load = 1'b1;
            div_src  = pend_q;
            state_d  = StRun;
          end
          if (!enable) begin
            state_d = StIdle;
            // Stopping anyway, so a ratio arriving on the stop edge loads as in IDLE
            if (state_q == StRun && xfer_ok) begin
              div_load = 1'b1;
              div_src  = cfg_div;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, counter and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      count_q   <= '0;
      pend_q    <= '0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      pend_q    <= pend_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
      err_q     <= err_d;
    end
  end

  // Active divide ratio, updated only on legal loads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= DivRst;
    end else if (div_load) begin
      div_q <= div_src;
    end
  end

`ifdef CTRL_DIV_STATUS_EN
  logic [15:0] periods_q;

  assign periods = periods_q;

  // Completed full periods since the last ratio load, saturating
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      periods_q <= '0;
    end else if (div_load) begin
      periods_q <= '0;
    end else if (fall && (periods_q != 16'hFFFF)) begin
      periods_q <= periods_q + 16'd1;
    end
  end
`endif

endmodule

// File: doc/controlador_divisor.md
Name: controlador_divisor

Overview:
- Run-time controller for the team's frequency divider path.
- Sequences start/stop of a programmable divided clock (`clk_out`) and its tick enable.
- Accepts new divide ratios over a valid/ready handshake and applies them only at full-period boundaries, so `clk_out` never glitches.
- Sits between the configuration/control logic and any downstream consumer of the slow clock or tick.

Parameters:
- WIDTH, 8, width of the divide ratio and the internal half-period counter.
- DEFAULT_DIV, 3, half-period length in `clk` cycles after reset. Must satisfy 1..2^WIDTH-1.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  level request to run the divider.
- cfg_valid  in  1  new ratio offered.
- cfg_div  in  WIDTH  requested half-period length in `clk` cycles.
- cfg_ready  out  1  controller can accept a ratio this cycle.
- cfg_err  out  1  one-cycle pulse: an offered ratio was rejected.
- clk_out  out  1  divided clock, period 2*div cycles, 50% duty.
- tick  out  1  one-cycle pulse on every `clk_out` transition.
- busy  out  1  controller in RUN or PEND.

Behaviour:
- Reset (async, immediate): state=IDLE, count=0, div_reg=DEFAULT_DIV, pending cleared, clk_out=0, tick=0, cfg_ready=1, cfg_err=0, busy=0.
- Handshake:
  - A transfer occurs on a rising edge with cfg_valid=1 and cfg_ready=1.
  - `cfg_div` is sampled only on a transfer.
- Ratio validation:
  - cfg_div=0: transfer completes, `cfg_err`=1 for exactly the next cycle, and div_reg and any pending value are unchanged.
  - cfg_div=1: legal; `clk_out` toggles every cycle.
- States:
  - IDLE:
    - count=0, clk_out=0, busy=0, cfg_ready=1.
    - A legal transfer loads div_reg on that edge.
    - enable=1 -> RUN on the next edge; count starts from 0 in the first RUN cycle.
  - RUN:
    - count increments each cycle.
    - Terminal: count >= div_reg-1. On terminal: count<=0, clk_out<=~clk_out, tick<=1. Otherwise tick<=0.
    - Hence tick is registered and coincident with the new `clk_out` level.
    - The first `clk_out` rise occurs div cycles after RUN entry.
    - cfg_ready=1. A legal transfer stores the value in the pending register -> PEND.
  - PEND:
    - Counting and toggling continue exactly as in RUN; cfg_ready=0.
    - At the terminal where clk_out goes 1->0 (full-period boundary): div_reg<=pending, then -> RUN.
    - The new ratio governs the very next half-period.
- Simultaneous transfer and terminal in RUN: the value goes to pending. It is not applied at that boundary, even if it is the falling one; it waits for the next falling boundary.
- enable=0 while in RUN or PEND:
  - Run continues until the next falling boundary (clk_out 1->0).
  - Any pending ratio is applied at that same edge; then -> IDLE.
  - If enable drops while clk_out=0, the current low phase completes, then the following high phase completes, then the controller stops at the falling boundary.
  - `clk_out` therefore always ends low, with no runt pulses.
- enable re-asserted before the stop boundary: the stop is cancelled and the controller stays in RUN/PEND.
- Wrap-around: count never exceeds div_reg-1. The >= comparison guards against a larger stale count.
- busy=1 in RUN and PEND, including the drain to the stop boundary; busy=0 in IDLE.
- Reset asserted mid-operation: all outputs return to reset values immediately; pending config is discarded.

Optional Feature:
- Macro CTRL_DIV_STATUS_EN.
- When defined:
  - Adds output `periods` (16 bits) counting completed full `clk_out` periods, incremented at each falling boundary.
  - Saturates at 0xFFFF.
  - Cleared to 0 by reset and on the edge where a new div_reg is applied.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, enable=1, DEFAULT_DIV=3 -> clk_out rises 3 cycles after RUN entry, period 6 cycles, tick pulses every 3 cycles, busy=1.
- In IDLE send cfg_div=5, then enable=1 -> transfer completes with cfg_ready=1; clk_out high 5 / low 5 cycles.
- Running at div=3 with clk_out=1, send cfg_div=2 -> cfg_ready=0 until the falling boundary; then high 2 / low 2; cfg_ready=1 again.
- Send cfg_div=0 in RUN -> cfg_err high exactly 1 cycle; period stays 6; state unchanged.
- Drop enable mid high phase at div=4 -> high phase completes (4 cycles total), clk_out=0, IDLE, busy=0, no further ticks.
- Assert rst mid-run with a pending ratio -> clk_out=0, cfg_ready=1, busy=0 immediately. After release, enable=1 gives period 2*DEFAULT_DIV; the pending ratio is lost.
